// File: rtl/spi_slave_sipo_if.sv
// Bundle of the SPI pins and host-side word/strobe signals of the SPI responder.
interface spi_slave_sipo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  SCLK;
    logic                  CS_n;
    logic                  MOSI;
    logic                  MISO;
    logic [1:0]            SPI_DATA_LEN;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  frame_err;

    modport slave (
        input  SCLK, CS_n, MOSI, SPI_DATA_LEN, tx_data, tx_load,
        output MISO, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output SCLK, CS_n, MOSI, SPI_DATA_LEN, tx_data, tx_load,
        input  MISO, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave_sipo.sv
// SPI mode-0 responder, MSB first: oversamples SCLK/CS_n/MOSI in the clk domain,
// receives one word per CS frame into rx_data and drives MISO from a tx buffer.
module spi_slave_sipo #(
    parameter int DATA_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    spi_slave_sipo_if.slave  bus
);
    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] HOLD  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [1:0]            state;
    logic                  sclk_p0, sclk_p1, sclk_p2;
    logic                  cs_p0, cs_p1, cs_p2;
    logic                  mosi_p0, mosi_p1;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      cnt;
    logic                  miso_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  rx_valid_r, busy_r, frame_err_r;

    function automatic logic [LEN_W-1:0] decode_len(input logic [1:0] code);
        return LEN_W'((int'(code) + 1) * 4);
    endfunction

    function automatic logic bit_at_top(input logic [DATA_WIDTH-1:0] word,
                                        input logic [LEN_W-1:0] len);
        logic [DATA_WIDTH-1:0] t;
        t = word >> (len - LEN_W'(1));
        return t[0];
    endfunction

    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [LEN_W-1:0]      new_len;
    logic [LEN_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] tx_src, tx_shl, rx_next;

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cs_fall   = ~cs_p1 & cs_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign new_len   = decode_len(bus.SPI_DATA_LEN);
    assign cnt_inc   = cnt + LEN_W'(1);
    assign tx_src    = bus.tx_load ? bus.tx_data : tx_buf;
    assign tx_shl    = tx_sh << 1;
    assign rx_next   = {rx_sh[DATA_WIDTH-2:0], mosi_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            // CS_n synchroniser resets to "selected" so HOLD waits for a real deselect
            sclk_p0     <= 1'b0;
            sclk_p1     <= 1'b0;
            sclk_p2     <= 1'b0;
            cs_p0       <= 1'b0;
            cs_p1       <= 1'b0;
            cs_p2       <= 1'b0;
            mosi_p0     <= 1'b0;
            mosi_p1     <= 1'b0;
            state       <= HOLD;
            tx_buf      <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            len_r       <= '0;
            cnt         <= '0;
            miso_r      <= 1'b0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            sclk_p0     <= bus.SCLK;
            sclk_p1     <= sclk_p0;
            sclk_p2     <= sclk_p1;
            cs_p0       <= bus.CS_n;
            cs_p1       <= cs_p0;
            cs_p2       <= cs_p1;
            mosi_p0     <= bus.MOSI;
            mosi_p1     <= mosi_p0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (bus.tx_load)
                tx_buf <= bus.tx_data;

            case (state)
                HOLD: begin
                    miso_r <= 1'b0;
                    if (cs_p1)
                        state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        len_r  <= new_len;
                        tx_sh  <= tx_src;
                        rx_sh  <= '0;
                        miso_r <= bit_at_top(tx_src, new_len);
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise && cnt < len_r) begin
                        frame_err_r <= 1'b1;
                        busy_r      <= 1'b0;
                        miso_r      <= 1'b0;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sh <= rx_next;
                        cnt   <= cnt_inc;
                        if (cnt_inc == len_r) begin
                            rx_data_r  <= rx_next;
                            rx_valid_r <= 1'b1;
                            busy_r     <= 1'b0;
                            miso_r     <= 1'b0;
                            state      <= HOLD;
                        end
                    end else if (sclk_fall && cnt < len_r) begin
                        tx_sh  <= tx_shl;
                        miso_r <= bit_at_top(tx_shl, len_r);
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.MISO      = miso_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_spi_slave_sipo.sv
// Bench for spi_slave_sipo: a bit-level SPI master (SCLK = clk/10) plus a word-level model.
module tb_spi_slave_sipo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_sipo_if #(.DATA_WIDTH(16)) bus();
    spi_slave_sipo #(.DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [15:0] m_tx;
    logic [15:0] m_rx;

    always @(negedge clk) begin
        if (bus.rx_valid)  n_valid++;
        if (bus.frame_err) n_err++;
    end

    typedef struct {
        logic [1:0]  code;
        logic [15:0] tx;
        logic [15:0] mosi;
        logic [15:0] exp_miso;
        logic [15:0] exp_rx;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        m_tx = w;
    endtask

    function automatic logic [15:0] mask(input int n);
        return 16'((32'h1 << n) - 1);
    endfunction

    task automatic sclk_bit(input logic mo, output logic mi);
        bus.MOSI = mo;
        tick(5);
        mi = bus.MISO;
        bus.SCLK = 1'b1;
        tick(5);
        bus.SCLK = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] mw, input int nbits, input int send_bits,
                             input int extra, input int load_at, input logic [15:0] load_word,
                             output logic [15:0] miso_w, output logic busy_mid);
        logic b;
        miso_w = '0;
        bus.CS_n = 1'b0;
        tick(5);
        busy_mid = bus.busy;
        for (int i = 0; i < send_bits; i++) begin
            if (i == load_at) begin
                bus.tx_data = load_word;
                bus.tx_load = 1'b1;
                tick(1);
                bus.tx_load = 1'b0;
            end
            sclk_bit(mw[nbits-1-i], b);
            miso_w = {miso_w[14:0], b};
        end
        for (int e = 0; e < extra; e++)
            sclk_bit(1'($urandom), b);
        tick(5);
        bus.CS_n = 1'b1;
        tick(10);
    endtask

    // Word-level model: expected MISO is the buffered word's low nbits, MSB first.
    task automatic do_frame(input string name, input logic [1:0] code, input logic [15:0] mw,
                            input int send_bits, input int extra, input int load_at,
                            input logic [15:0] load_word);
        int nbits, v0, e0;
        logic full, busy_mid;
        logic [15:0] miso_w, exp_miso;
        nbits = 4 * (int'(code) + 1);
        full  = (send_bits == nbits);
        bus.SPI_DATA_LEN = code;
        exp_miso = (m_tx & mask(nbits)) >> (nbits - send_bits);
        v0 = n_valid;
        e0 = n_err;
        run_frame(mw, nbits, send_bits, extra, load_at, load_word, miso_w, busy_mid);
        if (load_at >= 0) m_tx = load_word;
        if (full) m_rx = mw & mask(nbits);
        check($sformatf("%s miso", name), 32'(miso_w), 32'(exp_miso));
        check($sformatf("%s rx_data", name), 32'(bus.rx_data), 32'(m_rx));
        check($sformatf("%s rx_valid_cnt", name), n_valid - v0, full ? 1 : 0);
        check($sformatf("%s frame_err_cnt", name), n_err - e0, full ? 0 : 1);
        check($sformatf("%s busy_mid", name), 32'(busy_mid), 1);
        check($sformatf("%s busy_end", name), 32'(bus.busy), 0);
    endtask

    initial begin
        logic [15:0] miso_w, mw;
        logic        busy_mid, b;
        int          v0, e0, code, nbits, send;

        vecs[0] = '{2'b11, 16'hA5C3, 16'h24FF, 16'hA5C3, 16'h24FF};
        vecs[1] = '{2'b01, 16'h12AA, 16'h005C, 16'h00AA, 16'h005C};
        vecs[2] = '{2'b10, 16'hFABC, 16'h0123, 16'h0ABC, 16'h0123};
        vecs[3] = '{2'b00, 16'h0009, 16'hFFF6, 16'h0009, 16'h0006};

        rst = 1'b1;
        bus.SCLK = 1'b0;
        bus.CS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.SPI_DATA_LEN = 2'b11;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        m_tx = '0;
        m_rx = '0;
        tick(2);
        rst = 1'b0;
        check("reset MISO", 32'(bus.MISO), 0);
        check("reset rx_data", 32'(bus.rx_data), 0);
        check("reset rx_valid", 32'(bus.rx_valid), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset frame_err", 32'(bus.frame_err), 0);
        tick(5);

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].tx);
            bus.SPI_DATA_LEN = vecs[i].code;
            v0 = n_valid;
            e0 = n_err;
            nbits = 4 * (int'(vecs[i].code) + 1);
            run_frame(vecs[i].mosi, nbits, nbits, 0, -1, 16'h0, miso_w, busy_mid);
            m_rx = vecs[i].exp_rx;
            check($sformatf("vec%0d miso", i), 32'(miso_w), 32'(vecs[i].exp_miso));
            check($sformatf("vec%0d rx_data", i), 32'(bus.rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d rx_valid_cnt", i), n_valid - v0, 1);
            check($sformatf("vec%0d frame_err_cnt", i), n_err - e0, 0);
        end

        load(16'hBEEF);
        do_frame("abort", 2'b11, 16'h1357, 5, 0, -1, 16'h0);
        check("abort rx_kept", 32'(bus.rx_data), 32'h0006);
        do_frame("after_abort", 2'b11, 16'h2468, 16, 0, -1, 16'h0);

        load(16'hFFFF);
        do_frame("midload_1", 2'b11, 16'hC001, 16, 0, 6, 16'h0F0F);
        do_frame("midload_2", 2'b11, 16'h7007, 16, 0, -1, 16'h0);
        check("midload_2 word", 32'(m_tx), 32'h0F0F);
        do_frame("midload_3", 2'b11, 16'h0880, 16, 0, -1, 16'h0);

        // Reset pulse after 3 bits while the master keeps clocking the frame out.
        load(16'hFFFF);
        bus.SPI_DATA_LEN = 2'b11;
        v0 = n_valid;
        e0 = n_err;
        bus.CS_n = 1'b0;
        tick(5);
        for (int i = 0; i < 3; i++) sclk_bit(1'b1, b);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_tx = '0;
        m_rx = '0;
        miso_w = '0;
        for (int i = 0; i < 13; i++) begin
            sclk_bit(1'b1, b);
            miso_w = {miso_w[14:0], b};
        end
        check("rstmid busy_cs_low", 32'(bus.busy), 0);
        tick(5);
        bus.CS_n = 1'b1;
        tick(10);
        check("rstmid miso", 32'(miso_w), 0);
        check("rstmid rx_valid_cnt", n_valid - v0, 0);
        check("rstmid frame_err_cnt", n_err - e0, 0);
        check("rstmid rx_data", 32'(bus.rx_data), 0);
        load(16'h3C5A);
        do_frame("after_rst", 2'b11, 16'h9876, 16, 0, -1, 16'h0);

        load(16'h0006);
        do_frame("extra4", 2'b00, 16'h000B, 4, 4, -1, 16'h0);
        check("extra4 rx_data", 32'(bus.rx_data), 32'h000B);

        for (int r = 0; r < 24; r++) begin
            code  = $urandom_range(0, 3);
            nbits = 4 * (code + 1);
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            mw = 16'($urandom);
            send = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nbits - 1) : nbits;
            do_frame($sformatf("rand%0d", r), 2'(code), mw, send,
                     (send == nbits) ? $urandom_range(0, 2) : 0, -1, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
